// File: rtl/alu_mdu_iter_if.sv
// Execute-stage bus for alu_mdu_iter: ALU operands/controls and results,
// plus MDU issue/flush controls and the HI/LO/busy status.
//   master : pipeline side (drives operands and controls, reads results)
//   slave  : alu_mdu_iter (reads operands and controls, drives results)
interface alu_mdu_iter_if #(
  parameter int WIDTH = 32
);
  localparam int SHW = $clog2(WIDTH);

  logic [3:0]       alu_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [SHW-1:0]   shamt;
  logic             shift_v;
  logic             judge_ovf;
  logic [WIDTH-1:0] alu_result;
  logic             overflow;
  logic [2:0]       md_op;
  logic             md_start;
  logic             md_flush;
  logic             md_busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output alu_op, in_a, in_b, shamt, shift_v, judge_ovf, md_op, md_start, md_flush,
    input  alu_result, overflow, md_busy, hi, lo
  );

  modport slave (
    input  alu_op, in_a, in_b, shamt, shift_v, judge_ovf, md_op, md_start, md_flush,
    output alu_result, overflow, md_busy, hi, lo
  );
endinterface

// File: rtl/alu_mdu_iter.sv
// EX-stage unit: combinational WIDTH-bit ALU plus a fixed-latency
// multiply/divide unit that owns the HI/LO registers.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : alu_mdu_iter_if.slave (operands, alu_op/md_op controls,
//           alu_result/overflow, md_busy, hi, lo)
// MDU ops complete exactly MULT_CYCLES / DIV_CYCLES edges after the issue
// edge; md_flush aborts an op (or suppresses issue) without touching HI/LO.
module alu_mdu_iter #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  alu_mdu_iter_if.slave bus
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  // ---------------- ALU ----------------
  logic [SHW-1:0]   sa;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             ovf;

  assign sa = bus.shift_v ? bus.in_a[SHW-1:0] : bus.shamt;

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    // Sign-extended WIDTH+1 add/sub: top two bits disagree on signed overflow.
    sum     = (bus.alu_op == 4'd1) ? ({bus.in_a[WIDTH-1], bus.in_a} - {bus.in_b[WIDTH-1], bus.in_b})
                                   : ({bus.in_a[WIDTH-1], bus.in_a} + {bus.in_b[WIDTH-1], bus.in_b});
    case (bus.alu_op)
      4'd0, 4'd1: begin
        alu_res = sum[WIDTH-1:0];
        ovf     = bus.judge_ovf & (sum[WIDTH] != sum[WIDTH-1]);
      end
      4'd2:  alu_res = bus.in_a & bus.in_b;
      4'd3:  alu_res = bus.in_a | bus.in_b;
      4'd4:  alu_res = bus.in_a ^ bus.in_b;
      4'd5:  alu_res = ~(bus.in_a | bus.in_b);
      4'd6:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (bus.in_a < bus.in_b)};
      4'd8:  alu_res = bus.in_b << sa;
      4'd9:  alu_res = bus.in_b >> sa;
      4'd10: alu_res = $signed(bus.in_b) >>> sa;
      default: alu_res = '0;
    endcase
  end

  assign bus.alu_result = alu_res;
  assign bus.overflow   = ovf;

  // ---------------- MDU ----------------
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic             sgn_q, sgn_d, busy_q, busy_d;

  // Product: sign- or zero-extend to 2*WIDTH, low 2*WIDTH bits are exact.
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  assign ext_a = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign ext_b = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod  = ext_a * ext_b;

  // Divide on magnitudes, then fix signs. MIN/-1 falls out naturally:
  // |MIN| = MIN as unsigned, quotient negated back to MIN, remainder 0.
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] ua, ub, ub_nz, uq, ur, quo, rem;
  always_comb begin
    neg_a = sgn_q & a_q[WIDTH-1];
    neg_b = sgn_q & b_q[WIDTH-1];
    ua    = neg_a ? -a_q : a_q;
    ub    = neg_b ? -b_q : b_q;
    ub_nz = (ub == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : ub;
    uq    = ua / ub_nz;
    ur    = ua % ub_nz;
    quo   = (neg_a ^ neg_b) ? -uq : uq;
    rem   = neg_a ? -ur : ur;
    if (b_q == '0) begin
      quo = '1;
      rem = a_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.md_start && !bus.md_flush) begin
          case (bus.md_op)
            3'd1, 3'd2: begin
              state_d = S_MUL;
              cnt_d   = CW'(MULT_CYCLES);
              a_d     = bus.in_a;
              b_d     = bus.in_b;
              sgn_d   = (bus.md_op == 3'd1);
            end
            3'd3, 3'd4: begin
              state_d = S_DIV;
              cnt_d   = CW'(DIV_CYCLES);
              a_d     = bus.in_a;
              b_d     = bus.in_b;
              sgn_d   = (bus.md_op == 3'd3);
            end
            3'd5:    hi_d = bus.in_a;
            3'd6:    lo_d = bus.in_a;
            default: ;
          endcase
        end
      end
      default: begin
        if (bus.md_flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (state_q == S_MUL) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.md_busy = busy_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_alu_mdu_iter.sv
module tb_alu_mdu_iter;
  localparam int W = 32;
  localparam logic [2:0] MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_mdu_iter_if #(.WIDTH(W)) bus ();
  alu_mdu_iter #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errs = 0;
  int nchk = 0;
  logic [31:0] mhi = '0, mlo = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ALU reference: returns {overflow, result}
  function automatic logic [32:0] mdl_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] sh, input logic sv, input logic jo);
    int unsigned s_amt;
    longint s;
    logic [31:0] r;
    logic o;
    s_amt = sv ? a[4:0] : sh;
    r = '0;
    o = 1'b0;
    case (op)
      4'd0: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b)); o = jo && (s != longint'(int'(s))); end
      4'd1: begin r = a - b; s = longint'($signed(a)) - longint'($signed(b)); o = jo && (s != longint'(int'(s))); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~(a | b);
      4'd6: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7: r = (a < b) ? 32'd1 : 32'd0;
      4'd8: r = b << s_amt;
      4'd9: r = b >> s_amt;
      4'd10: r = 32'(int'(b) >>> s_amt);
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  // MDU reference: returns {hi, lo}
  function automatic logic [63:0] mdl_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int q, r;
    p = '0;
    case (op)
      MULT:  p = 64'(longint'($signed(a)) * longint'($signed(b)));
      MULTU: p = 64'(a) * 64'(b);
      DIV: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) p = {32'h0, 32'h80000000};
        else begin q = int'(a) / int'(b); r = int'(a) % int'(b); p = {32'(r), 32'(q)}; end
      end
      DIVU: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
      default: p = {mhi, mlo};
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic alu_t(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic sv, input logic jo);
    logic [32:0] e;
    bus.alu_op = op; bus.in_a = a; bus.in_b = b; bus.shamt = sh; bus.shift_v = sv; bus.judge_ovf = jo;
    #1;
    e = mdl_alu(op, a, b, sh, sv, jo);
    chk("alu_result", 64'(bus.alu_result), 64'(e[31:0]));
    chk("overflow", 64'(bus.overflow), 64'(e[32]));
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] e;
    n = (op == MULT || op == MULTU) ? 5 : 10;
    e = mdl_md(op, a, b);
    bus.md_op = op; bus.in_a = a; bus.in_b = b; bus.md_start = 1'b1;
    @(negedge clk);
    bus.md_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("busy_during", 64'(bus.md_busy), 64'd1);
      if (i == n - 1) chk("hilo_early", {bus.hi, bus.lo}, {mhi, mlo});
      @(negedge clk);
    end
    chk("busy_done", 64'(bus.md_busy), 64'd0);
    {mhi, mlo} = e;
    chk("hi", 64'(bus.hi), 64'(mhi));
    chk("lo", 64'(bus.lo), 64'(mlo));
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    bus.md_op = op; bus.in_a = a; bus.md_start = 1'b1;
    @(negedge clk);
    bus.md_start = 1'b0;
    if (op == MTHI) mhi = a; else mlo = a;
    chk("mt_busy", 64'(bus.md_busy), 64'd0);
    chk("mt_hilo", {bus.hi, bus.lo}, {mhi, mlo});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    bus.alu_op = '0; bus.in_a = '0; bus.in_b = '0; bus.shamt = '0; bus.shift_v = 1'b0;
    bus.judge_ovf = 1'b0; bus.md_op = '0; bus.md_start = 1'b0; bus.md_flush = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.md_busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed ALU vectors
    alu_t(4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0, 1'b1);
    chk("addu_res", 64'(bus.alu_result), 64'h80000000);
    chk("addu_ovf", 64'(bus.overflow), 64'd1);
    alu_t(4'd0, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0, 1'b0);
    chk("addu_noj", 64'(bus.overflow), 64'd0);
    alu_t(4'd10, 32'h4, 32'hF0000000, 5'd0, 1'b1, 1'b0);
    chk("sra", 64'(bus.alu_result), 64'hFF000000);
    alu_t(4'd6, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 1'b0);
    chk("slt", 64'(bus.alu_result), 64'd1);
    alu_t(4'd7, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0, 1'b0);
    chk("sltu", 64'(bus.alu_result), 64'd0);
    alu_t(4'd1, 32'h80000000, 32'h1, 5'd0, 1'b0, 1'b1);
    chk("subu_ovf", 64'(bus.overflow), 64'd1);
    alu_t(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b1);
    chk("and_noovf", 64'(bus.overflow), 64'd0);
    alu_t(4'd13, 32'h1234, 32'h5678, 5'd3, 1'b0, 1'b0);
    chk("undef_op", 64'(bus.alu_result), 64'd0);

    // Random ALU
    for (int i = 0; i < 60; i++)
      alu_t(4'($urandom_range(0, 11)), pick(), pick(), 5'($urandom), 1'($urandom), 1'($urandom));
    @(negedge clk);

    // Directed MDU vectors
    run_md(MULT, 32'hFFFFFFFE, 32'h3);
    chk("mult_hi", 64'(bus.hi), 64'hFFFFFFFF);
    chk("mult_lo", 64'(bus.lo), 64'hFFFFFFFA);
    run_md(MULTU, 32'hFFFFFFFE, 32'h3);
    chk("multu_hi", 64'(bus.hi), 64'h2);
    chk("multu_lo", 64'(bus.lo), 64'hFFFFFFFA);
    run_md(DIV, 32'hFFFFFFF9, 32'h2);
    chk("div_lo", 64'(bus.lo), 64'hFFFFFFFD);
    chk("div_hi", 64'(bus.hi), 64'hFFFFFFFF);
    run_md(DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("divmin_lo", 64'(bus.lo), 64'h80000000);
    chk("divmin_hi", 64'(bus.hi), 64'h0);
    run_md(DIVU, 32'h5, 32'h0);
    chk("divu0_lo", 64'(bus.lo), 64'hFFFFFFFF);
    chk("divu0_hi", 64'(bus.hi), 64'h5);

    // MTHI, then DIV flushed mid-flight; md_start while busy ignored
    mt(MTHI, 32'h12345678);
    bus.md_op = DIV; bus.in_a = 32'd100; bus.in_b = 32'd7; bus.md_start = 1'b1;
    @(negedge clk);                          // after issue edge T
    chk("fl_busy1", 64'(bus.md_busy), 64'd1);
    bus.md_op = MTLO; bus.in_a = 32'hDEADBEEF; // start during busy
    @(negedge clk);                          // after T+1
    bus.md_start = 1'b0;
    chk("busy_start_lo", 64'(bus.lo), 64'(mlo));
    chk("busy_start_busy", 64'(bus.md_busy), 64'd1);
    @(negedge clk);                          // after T+2
    @(negedge clk);                          // after T+3
    bus.md_flush = 1'b1;
    @(negedge clk);                          // after T+4
    bus.md_flush = 1'b0;
    chk("fl_busy0", 64'(bus.md_busy), 64'd0);
    chk("fl_hi", 64'(bus.hi), 64'h12345678);
    chk("fl_lo", 64'(bus.lo), 64'(mlo));
    repeat (10) @(negedge clk);
    chk("fl_later", {bus.hi, bus.lo}, {mhi, mlo});

    // Flush on the completing edge
    bus.md_op = MULT; bus.in_a = 32'd3; bus.in_b = 32'd4; bus.md_start = 1'b1;
    @(negedge clk);
    bus.md_start = 1'b0;
    repeat (4) @(negedge clk);               // after T+4
    bus.md_flush = 1'b1;
    @(negedge clk);                          // after T+5
    bus.md_flush = 1'b0;
    chk("flc_busy", 64'(bus.md_busy), 64'd0);
    chk("flc_hilo", {bus.hi, bus.lo}, {mhi, mlo});

    // Issue suppressed by flush in IDLE
    bus.md_op = MTHI; bus.in_a = 32'hAAAA5555; bus.md_start = 1'b1; bus.md_flush = 1'b1;
    @(negedge clk);
    bus.md_op = MULT;
    @(negedge clk);
    bus.md_start = 1'b0; bus.md_flush = 1'b0;
    chk("sup_busy", 64'(bus.md_busy), 64'd0);
    repeat (6) @(negedge clk);
    chk("sup_hilo", {bus.hi, bus.lo}, {mhi, mlo});

    // Reset mid-MULT, then MULTU right after release
    bus.md_op = MULT; bus.in_a = 32'h7; bus.in_b = 32'h9; bus.md_start = 1'b1;
    @(negedge clk);                          // after T
    bus.md_start = 1'b0;
    @(negedge clk);                          // after T+1
    @(negedge clk);                          // after T+2
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_hi", 64'(bus.hi), 64'd0);
    chk("mrst_lo", 64'(bus.lo), 64'd0);
    chk("mrst_busy", 64'(bus.md_busy), 64'd0);
    reset = 1'b1;
    mhi = '0; mlo = '0;
    @(negedge clk);
    run_md(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("post_rst_hi", 64'(bus.hi), 64'hFFFFFFFE);
    chk("post_rst_lo", 64'(bus.lo), 64'h1);

    // Random MDU
    for (int i = 0; i < 30; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(1, 6));
      if (op == MTHI || op == MTLO) mt(op, pick());
      else run_md(op, pick(), pick());
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
